// File: rtl/arb_pkg.sv
// Shared types and helpers for the arbiter family.
package arb_pkg;

  typedef enum logic {ARB_FIXED = 1'b0, ARB_RR = 1'b1} arb_mode_t;

  localparam int unsigned OH_W = 64;

  // OR of the set bit positions; exact for one-hot or all-zero input.
  function automatic int unsigned onehot_to_idx(input logic [OH_W-1:0] oh);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < OH_W; i++) begin
      if (oh[i]) idx = idx | i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational winner selection: highest index (fixed) or first set bit at/after ptr (round-robin).
module rr_pick
  import arb_pkg::*;
#(
  parameter  int N   = 4,
  localparam int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req_masked,
  input  logic [IDW-1:0] ptr,
  input  logic           mode,
  output logic [IDW-1:0] win_idx,
  output logic           win_valid
);

  logic [N-1:0]   at_or_above;
  logic [2*N-1:0] dbl;
  logic           found;

  always_comb begin
    at_or_above = '0;
    for (int unsigned i = 0; i < N; i++) begin
      at_or_above[i] = (IDW'(i) >= ptr);
    end
    // Lower half holds bits at/above ptr, upper half the full vector for wrap-around.
    dbl       = {req_masked, req_masked & at_or_above};
    win_valid = |req_masked;
    win_idx   = '0;
    found     = 1'b0;
    if (arb_mode_t'(mode) == ARB_RR) begin
      for (int unsigned i = 0; i < 2 * N; i++) begin
        if (dbl[i] && !found) begin
          win_idx = IDW'(i % N);
          found   = 1'b1;
        end
      end
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        if (req_masked[i]) win_idx = IDW'(i);
      end
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// N-way arbiter with registered one-hot grant, runtime fixed/round-robin mode and bounded grant hold.
module rr_arbiter
  import arb_pkg::*;
#(
  parameter  int N        = 4,
  parameter  int MAX_HOLD = 4,
  localparam int IDW      = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic           mode,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           gnt_valid
);

  localparam int HW = $clog2(MAX_HOLD + 1);

  logic [N-1:0]   gnt_q, gnt_d;
  logic [IDW-1:0] gnt_id_q, gnt_id_d;
  logic           gnt_valid_q, gnt_valid_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [HW-1:0]  hold_cnt_q, hold_cnt_d;

  logic [N-1:0]   others;
  logic [N-1:0]   req_masked;
  logic           cur_req, at_limit, keep, preempt;
  logic [IDW-1:0] win_idx;
  logic           win_valid;

  rr_pick #(.N(N)) u_pick (
    .req_masked(req_masked),
    .ptr       (ptr_q),
    .mode      (mode),
    .win_idx   (win_idx),
    .win_valid (win_valid)
  );

  always_comb begin
    // gnt_q is one-hot, so masking with it isolates the current holder's request.
    cur_req    = |(req & gnt_q);
    others     = req & ~gnt_q;
    at_limit   = (hold_cnt_q == HW'(MAX_HOLD - 1));
    keep       = cur_req && (!at_limit || (others == '0));
    preempt    = cur_req && at_limit && (others != '0);
    req_masked = preempt ? others : req;

    gnt_d      = '0;
    hold_cnt_d = '0;
    ptr_d      = ptr_q;
    if (keep) begin
      gnt_d      = gnt_q;
      hold_cnt_d = at_limit ? hold_cnt_q : hold_cnt_q + HW'(1);
    end else if (win_valid) begin
      gnt_d = N'(1) << win_idx;
      ptr_d = (win_idx == IDW'(N - 1)) ? '0 : win_idx + IDW'(1);
    end
    gnt_id_d    = IDW'(onehot_to_idx(OH_W'(gnt_d)));
    gnt_valid_d = |gnt_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q       <= '0;
      gnt_id_q    <= '0;
      gnt_valid_q <= 1'b0;
      ptr_q       <= '0;
      hold_cnt_q  <= '0;
    end else begin
      gnt_q       <= gnt_d;
      gnt_id_q    <= gnt_id_d;
      gnt_valid_q <= gnt_valid_d;
      ptr_q       <= ptr_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign gnt_valid = gnt_valid_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed bench for rr_arbiter: vector table on a 4-way/hold-4 instance, short sequences on hold-1 instances.
module tb_rr_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 4-way, MAX_HOLD=4
  logic       rst_a, mode_a;
  logic [3:0] req_a, gnt_a;
  logic [1:0] id_a;
  logic       vld_a;
  // 4-way, MAX_HOLD=1
  logic       rst_b, mode_b;
  logic [3:0] req_b, gnt_b;
  logic [1:0] id_b;
  logic       vld_b;
  // 5-way, MAX_HOLD=1
  logic       rst_c, mode_c;
  logic [4:0] req_c, gnt_c;
  logic [2:0] id_c;
  logic       vld_c;

  rr_arbiter #(.N(4), .MAX_HOLD(4)) u_dut_a (
    .clk(clk), .rst(rst_a), .req(req_a), .mode(mode_a),
    .gnt(gnt_a), .gnt_id(id_a), .gnt_valid(vld_a)
  );
  rr_arbiter #(.N(4), .MAX_HOLD(1)) u_dut_b (
    .clk(clk), .rst(rst_b), .req(req_b), .mode(mode_b),
    .gnt(gnt_b), .gnt_id(id_b), .gnt_valid(vld_b)
  );
  rr_arbiter #(.N(5), .MAX_HOLD(1)) u_dut_c (
    .clk(clk), .rst(rst_c), .req(req_c), .mode(mode_c),
    .gnt(gnt_c), .gnt_id(id_c), .gnt_valid(vld_c)
  );

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       mode;
    logic [3:0] gnt;
    logic [1:0] id;
    logic       vld;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(input logic r, input logic [3:0] q, input logic m,
                     input logic [3:0] g, input logic [1:0] i, input logic v, input int n);
    vec_t e;
    e.rst = r; e.req = q; e.mode = m; e.gnt = g; e.id = i; e.vld = v;
    for (int k = 0; k < n; k++) tbl.push_back(e);
  endtask

  task automatic check(input string name, input int step, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %b, want %b", name, step, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_a = 1'b1; req_a = '0; mode_a = 1'b0;
    rst_b = 1'b1; req_b = '0; mode_b = 1'b0;
    rst_c = 1'b1; req_c = '0; mode_c = 1'b0;

    // reset
    add(1, 4'b1111, 0, 4'b0000, 0, 0, 2);
    // fixed priority: hold 4, preempt to next highest, back again
    add(0, 4'b1111, 0, 4'b1000, 3, 1, 4);
    add(0, 4'b1111, 0, 4'b0100, 2, 1, 4);
    add(0, 4'b1111, 0, 4'b1000, 3, 1, 1);
    // sole requester through saturation, then release
    add(0, 4'b0010, 0, 4'b0010, 1, 1, 10);
    add(0, 4'b0000, 0, 4'b0000, 0, 0, 1);
    // early release in round-robin, fresh hold count afterwards
    add(0, 4'b0010, 1, 4'b0010, 1, 1, 1);
    add(0, 4'b0110, 1, 4'b0010, 1, 1, 1);
    add(0, 4'b0100, 1, 4'b0100, 2, 1, 1);
    add(0, 4'b0110, 1, 4'b0100, 2, 1, 3);
    add(0, 4'b0110, 1, 4'b0010, 1, 1, 1);
    // reset mid-hold
    add(0, 4'b1000, 1, 4'b1000, 3, 1, 2);
    add(1, 4'b1111, 1, 4'b0000, 0, 0, 1);
    add(0, 4'b1111, 1, 4'b0001, 0, 1, 1);
    // reset must clear a non-zero ptr
    add(0, 4'b0010, 1, 4'b0010, 1, 1, 1);
    add(1, 4'b1111, 1, 4'b0000, 0, 0, 1);
    add(0, 4'b1111, 1, 4'b0001, 0, 1, 1);
    // mode switch does not break a hold; applies at the preempt
    add(0, 4'b1111, 0, 4'b0001, 0, 1, 3);
    add(0, 4'b1111, 0, 4'b1000, 3, 1, 1);

    foreach (tbl[s]) begin
      rst_a = tbl[s].rst; req_a = tbl[s].req; mode_a = tbl[s].mode;
      tick();
      check("tbl_gnt", s, {4'b0, gnt_a}, {4'b0, tbl[s].gnt});
      check("tbl_id",  s, {6'b0, id_a},  {6'b0, tbl[s].id});
      check("tbl_vld", s, {7'b0, vld_a}, {7'b0, tbl[s].vld});
    end

    // round-robin rotation, MAX_HOLD=1
    begin
      logic [3:0] rot [5];
      rot[0] = 4'b0001; rot[1] = 4'b0010; rot[2] = 4'b0100; rot[3] = 4'b1000; rot[4] = 4'b0001;
      rst_b = 1'b1; tick();
      check("b_reset", 0, {4'b0, gnt_b}, 8'h00);
      rst_b = 1'b0; req_b = 4'b1111; mode_b = 1'b1;
      for (int k = 0; k < 5; k++) begin
        tick();
        check("b_rot_gnt", k, {4'b0, gnt_b}, {4'b0, rot[k]});
        check("b_rot_vld", k, {7'b0, vld_b}, 8'h01);
      end
      // sole requester keeps its grant even with MAX_HOLD=1
      req_b = 4'b0100;
      for (int k = 0; k < 3; k++) begin
        tick();
        check("b_sole_gnt", k, {4'b0, gnt_b}, 8'h04);
        check("b_sole_id",  k, {6'b0, id_b},  8'h02);
      end
    end

    // non-power-of-2 pointer wrap
    rst_c = 1'b1; tick();
    rst_c = 1'b0; req_c = 5'b10000; mode_c = 1'b1;
    tick();
    check("c_gnt4", 0, {3'b0, gnt_c}, 8'h10);
    check("c_id4",  0, {5'b0, id_c},  8'h04);
    req_c = 5'b10001;
    tick();
    check("c_wrap_gnt", 1, {3'b0, gnt_c}, 8'h01);
    check("c_wrap_id",  1, {5'b0, id_c},  8'h00);
    check("c_wrap_vld", 1, {7'b0, vld_c}, 8'h01);
    tick();
    check("c_back_gnt", 2, {3'b0, gnt_c}, 8'h10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
